// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg: shared state encoding and PIO register map for the edge-ack sequencer
package gpio_seq_pkg;
  typedef enum logic [3:0] {
    INIT_MASK, INIT_OUT, IDLE, RD_EDGE, RD_EDGE_W, CLR_EDGE,
    RD_DATA, RD_DATA_W, ACK_SET, ACK_HOLD, ACK_CLR, CMD_WR
  } state_t;
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;
endpackage

// File: rtl/gpio_pulse_timer.sv
// gpio_pulse_timer: loadable down-counter that flags when it has reached zero
module gpio_pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= load ? load_val : (dec && cnt != '0) ? cnt - 1'b1 : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/gpio_edge_ack_sequencer.sv
// gpio_edge_ack_sequencer: Avalon-MM master servicing PIO falling edges with a timed ack pulse
module gpio_edge_ack_sequencer
  import gpio_seq_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pio_irq,
  output logic [2:0]         pio_address,
  output logic               pio_chipselect,
  output logic               pio_write_n,
  output logic [31:0]        pio_writedata,
  input  logic [31:0]        pio_readdata,
  input  logic               enable,
  input  logic               cmd_valid,
  input  logic               cmd_level,
  output logic               cmd_ready,
  output logic               event_valid,
  output logic               event_level,
  output logic [COUNT_W-1:0] event_count,
  output logic               spurious,
  output logic               busy
);
  localparam int TW = $clog2(PULSE_CYCLES + 1);
  state_t state, fsm_next, next;
  logic armed, hold_done, acc_cs, acc_wn;
  logic [2:0] acc_addr;
  logic [31:0] acc_data;
  logic unused_rd;
  assign unused_rd = ^pio_readdata[31:1];
  gpio_pulse_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ACK_SET),
    .dec      (state == ACK_HOLD),
    .load_val (TW'(PULSE_CYCLES - 1)),
    .zero     (hold_done)
  );
  always_comb begin
    fsm_next = state;
    case (state)
      INIT_MASK: fsm_next = INIT_OUT;
      INIT_OUT:  fsm_next = IDLE;
      IDLE:      fsm_next = enable && pio_irq ? RD_EDGE : cmd_valid ? CMD_WR : IDLE;
      RD_EDGE:   fsm_next = RD_EDGE_W;
      RD_EDGE_W: fsm_next = pio_readdata[0] ? CLR_EDGE : IDLE;
      CLR_EDGE:  fsm_next = RD_DATA;
      RD_DATA:   fsm_next = RD_DATA_W;
      RD_DATA_W: fsm_next = ACK_SET;
      ACK_SET:   fsm_next = ACK_HOLD;
      ACK_HOLD:  fsm_next = hold_done ? ACK_CLR : ACK_HOLD;
      default:   fsm_next = IDLE;
    endcase
    next = armed ? fsm_next : INIT_MASK;
  end
  always_comb begin
    acc_cs = 1'b1;
    acc_wn = 1'b0;
    acc_addr = ADDR_DATA;
    acc_data = 32'd1;
    case (next)
      INIT_MASK: acc_addr = ADDR_MASK;
      INIT_OUT:  acc_data = 32'd0;
      RD_EDGE:   begin acc_wn = 1'b1; acc_addr = ADDR_EDGE; acc_data = 32'd0; end
      CLR_EDGE:  acc_addr = ADDR_EDGE;
      RD_DATA:   begin acc_wn = 1'b1; acc_data = 32'd0; end
      ACK_SET:   acc_addr = ADDR_SET;
      ACK_CLR:   acc_addr = ADDR_CLR;
      CMD_WR:    acc_addr = cmd_level ? ADDR_SET : ADDR_CLR;
      default:   begin acc_cs = 1'b0; acc_wn = 1'b1; acc_data = 32'd0; end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT_MASK;
      armed <= 1'b0;
      pio_chipselect <= 1'b0;
      pio_write_n <= 1'b1;
      pio_address <= ADDR_DATA;
      pio_writedata <= 32'd0;
      cmd_ready <= 1'b0;
      event_valid <= 1'b0;
      event_level <= 1'b0;
      event_count <= '0;
      spurious <= 1'b0;
      busy <= 1'b1;
    end else begin
      state <= next;
      armed <= 1'b1;
      pio_chipselect <= acc_cs;
      pio_write_n <= acc_wn;
      pio_address <= acc_addr;
      pio_writedata <= acc_data;
      cmd_ready <= next == CMD_WR;
      event_valid <= next == ACK_CLR;
      event_level <= state == RD_DATA_W ? pio_readdata[0] : event_level;
      event_count <= event_count + COUNT_W'(next == ACK_CLR);
      spurious <= state == RD_EDGE_W && !pio_readdata[0];
      busy <= next != IDLE;
    end
endmodule

// File: tb/tb_gpio_edge_ack_sequencer.sv
// tb_gpio_edge_ack_sequencer: directed vector bench with a behavioural edge-capture PIO slave
module tb_gpio_edge_ack_sequencer;
  localparam int PC = 4;
  localparam int CW = 2;
  typedef struct {
    int   kind;
    logic lvl;
    logic exp_level;
    int   exp_lat;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, cmd_valid = 1'b0, cmd_level = 1'b0;
  logic pio_irq, pio_chipselect, pio_write_n, cmd_ready, event_valid, event_level, spurious, busy;
  logic [2:0] pio_address;
  logic [31:0] pio_writedata, pio_readdata;
  logic [CW-1:0] event_count;
  logic in_port = 1'b1, in_prev = 1'b1, pio_data = 1'b0, pio_mask = 1'b0, pio_edge = 1'b0, force_irq = 1'b0;
  logic [31:0] rd_q = 32'd0;
  logic [7:0] acc_q[$];
  logic [CW-1:0] exp_count = '0;
  int n_checks = 0, n_fail = 0, cyc = 0;
  vec_t vecs[8];
  gpio_edge_ack_sequencer #(.PULSE_CYCLES(PC), .COUNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pio_irq        (pio_irq),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .enable         (enable),
    .cmd_valid      (cmd_valid),
    .cmd_level      (cmd_level),
    .cmd_ready      (cmd_ready),
    .event_valid    (event_valid),
    .event_level    (event_level),
    .event_count    (event_count),
    .spurious       (spurious),
    .busy           (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign pio_irq = (pio_edge & pio_mask) | force_irq;
  assign pio_readdata = rd_q;
  always @(posedge clk) begin
    in_prev <= in_port;
    if (pio_chipselect) acc_q.push_back({pio_write_n, pio_address, pio_writedata[3:0]});
    if (pio_chipselect && pio_write_n)
      rd_q <= {31'd0, pio_address == 3'd3 ? pio_edge : pio_address == 3'd2 ? pio_mask :
                      pio_address == 3'd0 ? in_port : 1'b0};
    if (pio_chipselect && !pio_write_n)
      case (pio_address)
        3'd0: pio_data <= pio_writedata[0];
        3'd2: pio_mask <= pio_writedata[0];
        3'd4: pio_data <= 1'b1;
        3'd5: pio_data <= 1'b0;
        default: ;
      endcase
    pio_edge <= (pio_chipselect && !pio_write_n && pio_address == 3'd3) ? 1'b0 : pio_edge | (in_prev & ~in_port);
  end
  function automatic logic [7:0] enc(input logic wn, input logic [2:0] a, input logic [3:0] d);
    return {wn, a, d};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_cs"}, pio_chipselect, 0);
    check({tag, "_wn"}, pio_write_n, 1);
    check({tag, "_addr"}, pio_address, 0);
    check({tag, "_wdata"}, pio_writedata, 0);
    check({tag, "_outs"}, {cmd_ready, event_valid, event_level, spurious}, 0);
    check({tag, "_count"}, event_count, 0);
    check({tag, "_busy"}, busy, 1);
  endtask
  task automatic check_init(input string tag);
    @(negedge clk);
    check({tag, "_init1"}, {pio_chipselect, pio_write_n, pio_address, pio_writedata[3:0]}, {1'b1, enc(0, 3'd2, 4'd1)});
    @(negedge clk);
    check({tag, "_init2"}, {pio_chipselect, pio_write_n, pio_address, pio_writedata[3:0]}, {1'b1, enc(0, 3'd0, 4'd0)});
    check({tag, "_init2_busy"}, busy, 1);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_cs"}, pio_chipselect, 0);
    check({tag, "_acc_n"}, acc_q.size(), 2);
    check({tag, "_mask"}, pio_mask, 1);
    check({tag, "_bit"}, pio_data, 0);
  endtask
  task automatic run_edge(input logic lvl, input logic exp_lvl, input int exp_lat);
    int t0, hi, lat;
    bit got;
    logic [7:0] exp_seq[5];
    exp_seq[0] = enc(1, 3'd3, 4'd0);
    exp_seq[1] = enc(0, 3'd3, 4'd1);
    exp_seq[2] = enc(1, 3'd0, 4'd0);
    exp_seq[3] = enc(0, 3'd4, 4'd1);
    exp_seq[4] = enc(0, 3'd5, 4'd1);
    in_port = 1'b1;
    @(negedge clk);
    @(negedge clk);
    acc_q.delete();
    in_port = 1'b0;
    @(negedge clk);
    in_port = lvl;
    t0 = cyc; hi = 0; got = 0; lat = 0;
    check("edge_irq_raised", pio_irq, 1);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      hi += int'(pio_data);
      if (event_valid) begin got = 1; lat = cyc - t0; end
    end
    check("edge_event_seen", got, 1);
    check("edge_latency", lat, exp_lat);
    check("edge_level", event_level, exp_lvl);
    exp_count++;
    check("edge_count", event_count, exp_count);
    @(negedge clk);
    hi += int'(pio_data);
    check("edge_ack_high_cycles", hi, PC + 1);
    check("edge_irq_cleared", pio_irq, 0);
    check("edge_busy_after", busy, 0);
    check("edge_event_pulse", event_valid, 0);
    check("edge_acc_n", acc_q.size(), 5);
    for (int i = 0; i < acc_q.size() && i < 5; i++) check("edge_acc_order", acc_q[i], exp_seq[i]);
  endtask
  task automatic run_cmd(input logic lvl, input logic exp_bit, input int exp_lat);
    int t0, lat;
    bit got;
    acc_q.delete();
    cmd_valid = 1'b1;
    cmd_level = lvl;
    t0 = cyc; got = 0; lat = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        lat = cyc - t0;
        check("cmd_strobe", {pio_chipselect, pio_write_n, pio_address, pio_writedata[3:0]},
              {1'b1, enc(0, lvl ? 3'd4 : 3'd5, 4'd1)});
      end
    end
    cmd_valid = 1'b0;
    check("cmd_ready_seen", got, 1);
    check("cmd_latency", lat, exp_lat);
    @(negedge clk);
    check("cmd_acc_n", acc_q.size(), 1);
    check("cmd_bit", pio_data, exp_bit);
    check("cmd_ready_pulse", cmd_ready, 0);
  endtask
  task automatic run_spur(input int exp_lat);
    int t0, lat;
    bit got;
    acc_q.delete();
    force_irq = 1'b1;
    t0 = cyc; got = 0; lat = 0;
    @(negedge clk);
    force_irq = 1'b0;
    check("spur_busy", busy, 1);
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (spurious) begin got = 1; lat = cyc - t0; check("spur_idle", busy, 0); end
    end
    check("spur_seen", got, 1);
    check("spur_latency", lat, exp_lat);
    @(negedge clk);
    check("spur_pulse", spurious, 0);
    check("spur_acc_n", acc_q.size(), 1);
    if (acc_q.size() > 0) check("spur_acc", acc_q[0], enc(1, 3'd3, 4'd0));
    check("spur_count", event_count, exp_count);
  endtask
  initial begin
    int ev_at, rdy_at;
    bit found;
    vecs[0] = '{0, 1'b0, 1'b0, 7 + PC};
    vecs[1] = '{0, 1'b1, 1'b1, 7 + PC};
    vecs[2] = '{1, 1'b1, 1'b1, 1};
    vecs[3] = '{1, 1'b0, 1'b0, 1};
    vecs[4] = '{2, 1'b0, 1'b0, 3};
    vecs[5] = '{0, 1'b0, 1'b0, 7 + PC};
    vecs[6] = '{0, 1'b1, 1'b1, 7 + PC};
    vecs[7] = '{0, 1'b0, 1'b0, 7 + PC};
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b0;
    acc_q.delete();
    check_init("boot");
    for (int v = 0; v < 8; v++)
      if (vecs[v].kind == 0) run_edge(vecs[v].lvl, vecs[v].exp_level, vecs[v].exp_lat);
      else if (vecs[v].kind == 1) run_cmd(vecs[v].lvl, vecs[v].exp_level, vecs[v].exp_lat);
      else run_spur(vecs[v].exp_lat);
    in_port = 1'b1;
    @(negedge clk);
    @(negedge clk);
    acc_q.delete();
    in_port = 1'b0;
    @(negedge clk);
    check("prio_irq", pio_irq, 1);
    cmd_valid = 1'b1;
    cmd_level = 1'b1;
    in_port = 1'b1;
    ev_at = -1; rdy_at = -1;
    for (int k = 0; k < 60 && rdy_at < 0; k++) begin
      @(negedge clk);
      if (event_valid && ev_at < 0) ev_at = cyc;
      if (cmd_ready) rdy_at = cyc;
    end
    cmd_valid = 1'b0;
    check("prio_event_seen", ev_at >= 0, 1);
    check("prio_ready_gap", rdy_at - ev_at, 2);
    exp_count++;
    check("prio_count", event_count, exp_count);
    @(negedge clk);
    check("prio_acc_n", acc_q.size(), 6);
    if (acc_q.size() == 6) begin
      check("prio_first", acc_q[0], enc(1, 3'd3, 4'd0));
      check("prio_last", acc_q[5], enc(0, 3'd4, 4'd1));
    end
    check("prio_bit", pio_data, 1);
    enable = 1'b0;
    in_port = 1'b0;
    acc_q.delete();
    repeat (50) @(negedge clk);
    check("en0_no_acc", acc_q.size(), 0);
    check("en0_irq_pending", pio_irq, 1);
    check("en0_idle", busy, 0);
    enable = 1'b1;
    @(negedge clk);
    check("en1_busy", busy, 1);
    check("en1_read_edge", {pio_chipselect, pio_write_n, pio_address}, {1'b1, 1'b1, 3'd3});
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (event_valid) found = 1;
    end
    exp_count++;
    check("en1_event_seen", found, 1);
    check("en1_count", event_count, exp_count);
    check("en1_level", event_level, 0);
    in_port = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_port = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (pio_chipselect && !pio_write_n && pio_address == 3'd4) found = 1;
    end
    check("hold_reached", found, 1);
    @(negedge clk);
    check("hold_bit_high", pio_data, 1);
    reset = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    reset = 1'b0;
    acc_q.delete();
    check_init("reboot");
    check("reboot_count", event_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gpio_edge_ack_sequencer.md
# gpio_edge_ack_sequencer

Avalon-MM master controlling a single-bit edge-capture PIO slave, with the slave's registered read data and its irq output. Programs the PIO's interrupt mask after reset, then services each captured falling edge in a fixed sequence:

1. Confirm the edge capture.
2. Clear the edge capture.
3. Sample the input level.
4. Emit a timed acknowledge pulse on the PIO output bit through its set/clear registers.

Between events it arbitrates a level-write command port onto the same slave. Edge service has priority.

## Interface
Parameters:
- PULSE_CYCLES, 4: cycles the ack bit is held high between set and clear writes; legal range ≥1.
- COUNT_W, 16: width of event_count.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- pio_irq  in  1  PIO interrupt (edge_capture & irq_mask).
- pio_address  out  3  PIO register select: 0 data, 2 mask, 3 edge, 4 set, 5 clear.
- pio_chipselect  out  1  access strobe, one cycle per access.
- pio_write_n  out  1  0 = write; 1 with chipselect = read.
- pio_writedata  out  32  write data.
- pio_readdata  in  32  PIO registered read data; bit 0 meaningful.
- enable  in  1  1 = service edges; 0 = leave pio_irq pending.
- cmd_valid  in  1  host request to drive the output bit.
- cmd_level  in  1  requested level: 1 writes addr 4, 0 writes addr 5, data 1.
- cmd_ready  out  1  command accepted this cycle (valid && ready).
- event_valid  out  1  one-cycle pulse when an edge service completes.
- event_level  out  1  pio_readdata[0] sampled at addr 0 during the last service.
- event_count  out  COUNT_W  completed services; wraps.
- spurious  out  1  one-cycle pulse when an edge read returns 0.
- busy  out  1  FSM not in IDLE.

## Operation
States:
- INIT_MASK: write addr 2 = 1. Go to INIT_OUT.
- INIT_OUT: write addr 0 = 0. Go to IDLE.
- IDLE: if enable && pio_irq, go to RD_EDGE. Otherwise, if cmd_valid, go to CMD_WR with cmd_ready = 1. Otherwise stay.
- RD_EDGE: read addr 3. Go to RD_EDGE_W.
- RD_EDGE_W: no access; sample pio_readdata[0].
  - If 1, go to CLR_EDGE.
  - If 0, pulse spurious and go to IDLE.
- CLR_EDGE: write addr 3 (any data). Go to RD_DATA.
- RD_DATA: read addr 0. Go to RD_DATA_W.
- RD_DATA_W: capture event_level. Go to ACK_SET.
- ACK_SET: write addr 4 = 1 and load the hold counter with PULSE_CYCLES−1. Go to ACK_HOLD.
- ACK_HOLD: no access; decrement the counter. At 0, go to ACK_CLR.
- ACK_CLR: write addr 5 = 1, pulse event_valid, increment event_count. Go to IDLE.
- CMD_WR: write addr 4 or addr 5 with data 1, using the latched cmd_level. Go to IDLE.

Rules:
- Outside an access cycle: pio_chipselect = 0, pio_write_n = 1, pio_address = 0, pio_writedata = 0.
- pio_irq is not re-sampled mid-service. An edge arriving after CLR_EDGE re-raises irq, and it is serviced on the next pass through IDLE.
- A write to addr 3 is never issued without a preceding confirmed read of addr 3.
- Deasserting enable mid-service does not abort; the sequence completes.
- cmd_ready is asserted only in IDLE when no edge is being taken. A command arriving during service waits.
- event_count wraps from 2^COUNT_W−1 to 0.

## Timing
- All outputs are registered.
- Reset values: state INIT_MASK; pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0; cmd_ready 0, event_valid 0, event_level 0, event_count 0, spurious 0, busy 1.
- Reset asserted mid-sequence aborts immediately. The init writes reissue after release, leaving the output bit at 0.
- Read latency: address is presented in cycle N and pio_readdata is sampled at the end of cycle N+1.
- Writes take a single cycle.
- Service latency from pio_irq sampled in IDLE to event_valid: 7 + PULSE_CYCLES cycles. The output bit is high for PULSE_CYCLES + 1 cycles of the PIO's data register.
- First IDLE is 2 cycles after reset release.
- A command takes 1 cycle from acceptance to the write strobe.

## Structure
- Shared package gpio_seq_pkg:
  - state enum
  - PIO register address constants: ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3, ADDR_SET = 4, ADDR_CLR = 5
- One sub-module, gpio_pulse_timer: loadable down-counter with a terminal flag, $clog2(PULSE_CYCLES+1) bits.

## Test plan
- Reset release with a PIO model attached → writes (2,1) then (0,0) on consecutive cycles; busy falls in cycle 3.
- Falling edge on the PIO input, in_port then held 0, PULSE_CYCLES = 4 → access order: read 3, write 3, read 0, write 4, write 5. event_valid fires 11 cycles after irq is seen; event_level = 0; event_count = 1; irq low afterwards.
- Forced pio_irq = 1 with edge read returning 0 → spurious pulse, no write to addr 3/4/5, back in IDLE in 3 cycles.
- cmd_valid = 1, cmd_level = 1, asserted in the same cycle as pio_irq → irq is serviced first; cmd_ready only after event_valid; then a single write to addr 4.
- enable = 0 with pio_irq high for 50 cycles → no accesses; enable = 1 → service starts the next cycle.
- COUNT_W = 2, 5 events → event_count sequence 1, 2, 3, 0, 1. Reset asserted during ACK_HOLD → outputs at reset values and init writes repeated.
